// File: rtl/alarma_pkg.sv
// Shared definitions for the zoned alarm controller: state codes, counter
// width, default delays and small helpers used by the FSM.
package alarma_pkg;

    localparam int CNT_W          = 5;
    localparam int N_ZONAS        = 4;
    localparam int T_SALIDA_DEF   = 16;
    localparam int T_ENTRADA_DEF  = 8;
    localparam int T_SIRENA_DEF   = 30;

    typedef enum logic [2:0] {
        DESCONECTADA = 3'd0,
        ESPERA       = 3'd1,
        ACTIVADA     = 3'd2,
        ENTRADA      = 3'd3,
        ALARMA       = 3'd4
    } estado_t;

    // Saturating decrement: the delay counter must never wrap below zero.
    function automatic logic [CNT_W-1:0] decrementa(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    // Lowest active perimeter zone (1..3); only meaningful when any bit is set.
    function automatic logic [1:0] zona_mas_baja(input logic [3:1] z);
        if (z[1]) begin
            return 2'd1;
        end else if (z[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for asynchronous level inputs, with synchronous
// active-low reset clearing both stages.
module sincronizador #(
    parameter int W = 4
) (
    input  logic         i_clock,
    input  logic         i_areset_n,
    input  logic [W-1:0] i_dato,
    output logic [W-1:0] o_dato
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // NOTE: non-blocking assignments make both stages sample the old values on
    // the same edge; blocking here would collapse the chain into one flop.
    always_ff @(posedge i_clock) begin
        if (!i_areset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_dato;
            r_sync <= r_meta;
        end
    end

    assign o_dato = r_sync;

endmodule

// File: rtl/control_alarma_zonas.sv
// Four-zone alarm controller: exit delay, door entry delay, timed siren and
// cause-of-alarm reporting, all outputs registered with the state.
module control_alarma_zonas
    import alarma_pkg::*;
#(
    parameter int T_SALIDA  = T_SALIDA_DEF,
    parameter int T_ENTRADA = T_ENTRADA_DEF,
    parameter int T_SIRENA  = T_SIRENA_DEF
) (
    input  logic               clock,
    input  logic               areset_n,
    input  logic               inicio,
    input  logic [N_ZONAS-1:0] intruso,
    input  logic [N_ZONAS-1:0] mascara,
    output logic               sirena,
    output logic [1:0]         zona,
    output logic [2:0]         estado,
    output logic [CNT_W-1:0]   cuenta
);

    localparam logic [CNT_W-1:0] L_SALIDA  = CNT_W'(T_SALIDA - 1);
    localparam logic [CNT_W-1:0] L_ENTRADA = CNT_W'(T_ENTRADA - 1);
    localparam logic [CNT_W-1:0] L_SIRENA  = CNT_W'(T_SIRENA - 1);

    logic [N_ZONAS-1:0] w_sync;
    logic [N_ZONAS-1:0] w_zs;
    logic               w_hay_perimetro;
    logic [1:0]         w_zona_perimetro;

    estado_t            r_estado;
    logic               r_sirena;
    logic [1:0]         r_zona;
    logic [CNT_W-1:0]   r_cuenta;

    sincronizador #(
        .W (N_ZONAS)
    ) u_sincronizador (
        .i_clock    (clock),
        .i_areset_n (areset_n),
        .i_dato     (intruso),
        .o_dato     (w_sync)
    );

    assign w_zs             = w_sync & mascara;
    assign w_hay_perimetro  = |w_zs[3:1];
    assign w_zona_perimetro = zona_mas_baja(w_zs[3:1]);

    // Siren is written in the same branch as every state change so that it is
    // high exactly while the state register holds ALARMA.
    always_ff @(posedge clock) begin
        if (!areset_n) begin
            r_estado <= DESCONECTADA;
            r_sirena <= 1'b0;
            r_zona   <= '0;
            r_cuenta <= '0;
        end else if (!inicio) begin
            r_estado <= DESCONECTADA;
            r_sirena <= 1'b0;
            r_cuenta <= '0;
        end else begin
            case (r_estado)
                DESCONECTADA: begin
                    r_estado <= ESPERA;
                    r_sirena <= 1'b0;
                    r_cuenta <= L_SALIDA;
                end

                ESPERA: begin
                    if (r_cuenta == '0) begin
                        r_estado <= ACTIVADA;
                    end else begin
                        r_cuenta <= decrementa(r_cuenta);
                    end
                end

                ACTIVADA: begin
                    if (w_hay_perimetro) begin
                        r_estado <= ALARMA;
                        r_sirena <= 1'b1;
                        r_cuenta <= L_SIRENA;
                        r_zona   <= w_zona_perimetro;
                    end else if (w_zs[0]) begin
                        r_estado <= ENTRADA;
                        r_cuenta <= L_ENTRADA;
                        r_zona   <= 2'd0;
                    end
                end

                ENTRADA: begin
                    if (w_hay_perimetro) begin
                        r_estado <= ALARMA;
                        r_sirena <= 1'b1;
                        r_cuenta <= L_SIRENA;
                        r_zona   <= w_zona_perimetro;
                    end else if (r_cuenta == '0) begin
                        r_estado <= ALARMA;
                        r_sirena <= 1'b1;
                        r_cuenta <= L_SIRENA;
                    end else begin
                        r_cuenta <= decrementa(r_cuenta);
                    end
                end

                ALARMA: begin
                    if (r_cuenta == '0) begin
                        r_estado <= ACTIVADA;
                        r_sirena <= 1'b0;
                    end else begin
                        r_cuenta <= decrementa(r_cuenta);
                    end
                end

                default: begin
                    r_estado <= DESCONECTADA;
                    r_sirena <= 1'b0;
                    r_cuenta <= '0;
                end
            endcase
        end
    end

    assign sirena = r_sirena;
    assign zona   = r_zona;
    assign estado = r_estado;
    assign cuenta = r_cuenta;

endmodule
